// File: rtl/eeg_deser_scheduler.sv
// Frame-locked serial deserialiser for the EEG front end: hunts a frame-sync marker, packs
// WIDTH-bit words LSB-first and tags them with a round-robin channel index on a valid/ready port.
module eeg_deser_scheduler #(
    parameter int unsigned WIDTH  = 4,
    parameter int unsigned NUM_CH = 4,
    parameter int unsigned CH_W   = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             enable,
    input  logic             frame_sync,
    input  logic             sEEG,
    input  logic             out_ready,
    input  logic             clr_err,
    output logic [WIDTH-1:0] word_data,
    output logic [CH_W-1:0]  word_ch,
    output logic             word_valid,
    output logic             frame_done,
    output logic             overflow,
    output logic             sync_err
);

    localparam int unsigned     BW       = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [BW-1:0]   BIT_LAST = BW'(WIDTH - 1);
    localparam logic [CH_W-1:0] CH_LAST  = CH_W'(NUM_CH - 1);

    typedef enum logic [1:0] {StIdle, StWaitSync, StShift} state_t;

    state_t            r_state, w_state;
    logic [WIDTH-1:0]  r_shift, w_shift, w_shifted;
    logic [BW-1:0]     r_bit_cnt, w_bit_cnt;
    logic [CH_W-1:0]   r_ch_cnt, w_ch_cnt;
    logic [WIDTH-1:0]  r_word_data;
    logic [CH_W-1:0]   r_word_ch;
    logic              r_word_valid, r_frame_done, r_overflow, r_sync_err;
    logic              w_complete, w_resync, w_last, w_xfer, w_load, w_drop;

    // New bit enters at the MSB so the first-received bit ends up at the LSB.
    assign w_shifted = {sEEG, r_shift[WIDTH-1:1]};

    always_comb begin
        w_state    = r_state;
        w_shift    = r_shift;
        w_bit_cnt  = r_bit_cnt;
        w_ch_cnt   = r_ch_cnt;
        w_complete = 1'b0;
        w_resync   = 1'b0;
        case (r_state)
            StIdle: begin
                if (enable) w_state = StWaitSync;
            end
            StWaitSync: begin
                if (!enable) begin
                    w_state = StIdle;
                end else if (frame_sync) begin
                    w_shift   = w_shifted;
                    w_bit_cnt = BW'(1);
                    w_ch_cnt  = '0;
                    w_state   = StShift;
                end
            end
            StShift: begin
                w_shift = w_shifted;
                // Resync beats word completion: the partial word is simply abandoned.
                if (frame_sync) begin
                    w_resync  = 1'b1;
                    w_bit_cnt = BW'(1);
                    w_ch_cnt  = '0;
                end else if (r_bit_cnt == BIT_LAST) begin
                    w_complete = 1'b1;
                    w_bit_cnt  = '0;
                    if (r_ch_cnt == CH_LAST) begin
                        w_ch_cnt = '0;
                        w_state  = StWaitSync;
                    end else begin
                        w_ch_cnt = r_ch_cnt + 1'b1;
                    end
                end else begin
                    w_bit_cnt = r_bit_cnt + 1'b1;
                end
                if (!enable) begin
                    w_state   = StIdle;
                    w_bit_cnt = '0;
                    w_ch_cnt  = '0;
                end
            end
            default: w_state = StIdle;
        endcase
    end

    assign w_last = w_complete && (r_ch_cnt == CH_LAST);
    assign w_xfer = r_word_valid && out_ready;
    assign w_load = w_complete && (!r_word_valid || w_xfer);
    assign w_drop = w_complete && !w_load;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= StIdle;
            r_shift      <= '0;
            r_bit_cnt    <= '0;
            r_ch_cnt     <= '0;
            r_word_data  <= '0;
            r_word_ch    <= '0;
            r_word_valid <= 1'b0;
            r_frame_done <= 1'b0;
            r_overflow   <= 1'b0;
            r_sync_err   <= 1'b0;
        end else begin
            r_state      <= w_state;
            r_shift      <= w_shift;
            r_bit_cnt    <= w_bit_cnt;
            r_ch_cnt     <= w_ch_cnt;
            r_frame_done <= w_last;
            if (w_load) begin
                r_word_data  <= w_shifted;
                r_word_ch    <= r_ch_cnt;
                r_word_valid <= 1'b1;
            end else if (w_xfer) begin
                r_word_valid <= 1'b0;
            end
            // A set event in the same cycle as clr_err keeps the flag high.
            r_overflow <= (r_overflow && !clr_err) || w_drop;
            r_sync_err <= (r_sync_err && !clr_err) || w_resync;
        end
    end

    assign word_data  = r_word_data;
    assign word_ch    = r_word_ch;
    assign word_valid = r_word_valid;
    assign frame_done = r_frame_done;
    assign overflow   = r_overflow;
    assign sync_err   = r_sync_err;

endmodule

// File: tb/tb_eeg_deser_scheduler.sv
// Scoreboard bench for eeg_deser_scheduler: a bit-queue reference model predicts words and
// flags; a negedge monitor compares DUT outputs and pops expected words on each transfer.
module tb_eeg_deser_scheduler;

    localparam int W  = 4;
    localparam int NC = 4;
    localparam int CW = 2;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          enable = 1'b0;
    logic          frame_sync = 1'b0;
    logic          sEEG = 1'b0;
    logic          out_ready = 1'b0;
    logic          clr_err = 1'b0;
    logic [W-1:0]  word_data;
    logic [CW-1:0] word_ch;
    logic          word_valid, frame_done, overflow, sync_err;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    eeg_deser_scheduler #(.WIDTH(W), .NUM_CH(NC), .CH_W(CW)) u_dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .enable     (enable),
        .frame_sync (frame_sync),
        .sEEG       (sEEG),
        .out_ready  (out_ready),
        .clr_err    (clr_err),
        .word_data  (word_data),
        .word_ch    (word_ch),
        .word_valid (word_valid),
        .frame_done (frame_done),
        .overflow   (overflow),
        .sync_err   (sync_err)
    );

    // Reference model: mode 0 = idle, 1 = hunting for sync, 2 = inside a frame.
    int m_mode;
    int m_ch;
    int m_bits[$];
    bit m_valid, m_ovf, m_se, m_fd;
    int exp_q[$];
    int got_q[$];
    int n_fd;

    task automatic check(input string name, input logic [31:0] got, input int want);
        n_cmp++;
        if (got !== 32'(want)) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, got, want, $time);
        end
    endtask

    task automatic model_reset();
        m_mode = 0;
        m_ch = 0;
        m_bits.delete();
        m_valid = 0;
        m_ovf = 0;
        m_se = 0;
        m_fd = 0;
        exp_q.delete();
    endtask

    // One clock edge worth of behaviour, using the inputs the DUT just sampled.
    task automatic model_step();
        bit trans, load, ovf_set, se_set, fd;
        int word;
        trans = m_valid && out_ready;
        load = 0; ovf_set = 0; se_set = 0; fd = 0; word = 0;
        if (m_mode == 0) begin
            if (enable) m_mode = 1;
        end else if (m_mode == 1) begin
            if (!enable) m_mode = 0;
            else if (frame_sync) begin
                m_bits.delete();
                m_bits.push_back(int'(sEEG));
                m_ch = 0;
                m_mode = 2;
            end
        end else begin
            if (frame_sync) begin
                se_set = 1;
                m_bits.delete();
                m_bits.push_back(int'(sEEG));
                m_ch = 0;
            end else begin
                m_bits.push_back(int'(sEEG));
                if (m_bits.size() == W) begin
                    for (int i = 0; i < W; i++) word += m_bits[i] << i;
                    if (!m_valid || trans) begin
                        load = 1;
                        exp_q.push_back((m_ch << W) | word);
                    end else begin
                        ovf_set = 1;
                    end
                    m_bits.delete();
                    if (m_ch == NC - 1) begin
                        fd = 1;
                        m_ch = 0;
                        m_mode = 1;
                    end else begin
                        m_ch++;
                    end
                end
            end
            if (!enable) begin
                m_mode = 0;
                m_bits.delete();
                m_ch = 0;
            end
        end
        if (load) m_valid = 1;
        else if (trans) m_valid = 0;
        m_ovf = (m_ovf && !clr_err) || ovf_set;
        m_se = (m_se && !clr_err) || se_set;
        m_fd = fd;
    endtask

    // Inputs change 2 time units after the edge; the model tracks the edge just taken.
    task automatic drive(input bit en, input bit fs, input bit d, input bit rdy, input bit clr,
                         input bit rst = 1'b1);
        @(posedge clk);
        #2;
        if (rst_n) model_step();
        else model_reset();
        rst_n = rst;
        enable = en;
        frame_sync = fs;
        sEEG = d;
        out_ready = rdy;
        clr_err = clr;
        if (!rst_n) model_reset();
    endtask

    task automatic send_frame(input logic [15:0] bits, input logic [15:0] fs_m,
                              input logic [15:0] en_m, input logic [15:0] rdy_m,
                              input int tail, input bit tail_en, input bit tail_rdy);
        drive(1'b1, 1'b0, 1'b0, rdy_m[0], 1'b0);
        for (int i = 0; i < 16; i++) drive(en_m[i], fs_m[i], bits[i], rdy_m[i], 1'b0);
        for (int i = 0; i < tail; i++) drive(tail_en, 1'b0, 1'b0, tail_rdy, 1'b0);
    endtask

    // Monitor: compare every cycle, pop the expected word when a transfer will occur.
    initial begin
        forever begin
            @(negedge clk);
            check("word_valid", 32'(word_valid), int'(m_valid));
            check("overflow", 32'(overflow), int'(m_ovf));
            check("sync_err", 32'(sync_err), int'(m_se));
            check("frame_done", 32'(frame_done), int'(m_fd));
            if (frame_done === 1'b1) n_fd++;
            if (m_valid) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL word: model holds a word but scoreboard queue is empty");
                end else begin
                    check("word", 32'({word_ch, word_data}), exp_q[0]);
                    if (out_ready) begin
                        got_q.push_back(int'({word_ch, word_data}));
                        void'(exp_q.pop_front());
                    end
                end
            end
        end
    end

    localparam logic [15:0] Bits = 16'h2F8D;

    initial begin
        model_reset();
        n_fd = 0;
        repeat (3) drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

        // Reset mid-frame after two bits, then a clean restart.
        drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        drive(1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
        drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        drive(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        #1;
        check("rst_valid", 32'(word_valid), 0);
        check("rst_outs", 32'({word_data, word_ch, frame_done, overflow, sync_err}), 0);
        drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);

        // Nominal frame, out_ready held high.
        got_q.delete(); n_fd = 0;
        send_frame(Bits, 16'h0001, 16'hFFFF, 16'hFFFF, 3, 1'b1, 1'b1);
        check("f1_count", 32'(got_q.size()), 4);
        if (got_q.size() == 4) begin
            check("f1_w0", 32'(got_q[0]), 'h0D);
            check("f1_w1", 32'(got_q[1]), 'h18);
            check("f1_w2", 32'(got_q[2]), 'h2F);
            check("f1_w3", 32'(got_q[3]), 'h32);
        end
        check("f1_frame_done", 32'(n_fd), 1);

        // Backpressure for a whole frame: ch0 held, rest dropped.
        got_q.delete();
        send_frame(Bits, 16'h0001, 16'hFFFF, 16'h0000, 3, 1'b1, 1'b0);
        check("bp_overflow", 32'(overflow), 1);
        check("bp_held", 32'({word_valid, word_ch, word_data}), 'h4D);
        drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        check("bp_drained", 32'(word_valid), 0);
        check("bp_got", (got_q.size() == 1) ? 32'(got_q[0]) : 32'hFFFF, 'h0D);
        drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
        drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);

        // Drain and load on the same edge at ch1's last bit.
        got_q.delete();
        send_frame(Bits, 16'h0001, 16'hFFFF, 16'hFF80, 3, 1'b1, 1'b1);
        check("dl_overflow", 32'(overflow), 0);
        check("dl_count", 32'(got_q.size()), 4);

        // Resync on the third bit of ch2.
        got_q.delete();
        send_frame(Bits, 16'h0401, 16'hFFFF, 16'hFFFF, 12, 1'b1, 1'b1);
        check("rs_sync_err", 32'(sync_err), 1);
        check("rs_new_ch0", (got_q.size() >= 3) ? 32'(got_q[2]) : 32'hFFFF, 'h0B);
        drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
        drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        check("rs_cleared", 32'(sync_err), 0);

        // Enable dropped on ch1's second bit, then a clean frame.
        got_q.delete(); n_fd = 0;
        send_frame(Bits, 16'h0001, 16'h001F, 16'hFFFF, 3, 1'b0, 1'b1);
        check("en_words", 32'(got_q.size()), 1);
        check("en_no_done", 32'(n_fd), 0);
        got_q.delete();
        send_frame(Bits, 16'h0001, 16'hFFFF, 16'hFFFF, 3, 1'b1, 1'b1);
        check("en_restart", (got_q.size() == 4) ? 32'(got_q[0]) : 32'hFFFF, 'h0D);

        // Randomised traffic, scoreboard-checked.
        for (int c = 0; c < 4000; c++) begin
            bit en, fs, d, rdy, clr, rst;
            en  = $urandom_range(0, 99) < 97;
            fs  = (m_mode == 1) ? ($urandom_range(0, 99) < 50) : ($urandom_range(0, 99) < 2);
            d   = 1'($urandom_range(0, 1));
            rdy = $urandom_range(0, 99) < 60;
            clr = $urandom_range(0, 99) < 5;
            rst = $urandom_range(0, 999) >= 4;
            drive(en, fs, d, rdy, clr, rst);
        end
        repeat (8) drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        check("final_drain", 32'(exp_q.size()), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
